srai_accel_ctrl_slave: RTL and testbench
========================================

Name: srai_accel_ctrl_slave

Overview:
- AXI-Lite responder (slave end) for the accelerator control/status register file.
- Sits between the host-side AXI-Lite master (PCIe bridge / interconnect) and an HLS kernel's ap_ctrl_hs block-level handshake.
- Provides start/done/idle/ready control, an interrupt with enable/status registers, and NUM_ARGS 32-bit scalar argument registers driven to the kernel.

Parameters:
- ADDR_W, 12, AXI-Lite address width; must equal the shared AXI_LITE_AW macro.
- DATA_W, 32, AXI-Lite data width; only 32 is supported.
- NUM_ARGS, 8, number of scalar argument registers (1..32).

Ports:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- s_axi  slave modport  -  AXI-Lite slave port using srai_accel_AXI_LITE_intfc.slave. Signals: awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready.
- ap_start  out  1  kernel start.
- ap_done  in  1  kernel done pulse.
- ap_idle  in  1  kernel idle level.
- ap_ready  in  1  kernel ready pulse (inputs consumed).
- args  out  NUM_ARGS*32  argument registers, arg i at bits [32i+31:32i].
- interrupt  out  1  level interrupt = GIE & |(ISR & IER).

Behaviour:
Reset (async assert, sync deassert):
- All ready/valid outputs are 0; bresp, rresp and rdata are 0.
- ap_start, GIE, IER, ISR, done_latch, auto_restart, args and interrupt are 0.
- AXI awready, wready and arready go to 1 on the first clock after reset release.

Register map (byte address; bits [1:0] ignored):
- 0x00 CTRL: b0 ap_start (RW), b1 ap_done (RO, clear-on-read), b2 ap_idle (RO, live), b3 ap_ready (RO, live pulse), b7 auto_restart (RW).
- 0x04 GIE: b0.
- 0x08 IER: b0 done, b1 ready.
- 0x0C ISR: b0 done, b1 ready; write-1-to-clear.
- 0x10+4*i ARG[i], i < NUM_ARGS: RW, byte-masked by wstrb.
- Unmapped addresses: reads return 0, writes are dropped. Response is always OKAY (2'b00).

Write channel FSM W_IDLE -> W_RESP:
- AW and W are accepted independently, in either order or in the same cycle.
- awready drops after AW is captured; wready drops after W is captured.
- The register update happens in the cycle after both are held. bvalid asserts that same cycle; state is W_RESP.
- bvalid holds until bready. In the cycle after the handshake, awready and wready return to 1 and state is W_IDLE.
- At most one write is outstanding.

Read channel FSM R_IDLE -> R_DATA:
- An arvalid&arready handshake captures the address. rdata/rvalid are registered and appear the next cycle (1-cycle latency).
- arready is 0 while rvalid is high.
- rdata and rvalid hold stable until rready. arready returns to 1 on the cycle after the handshake.

ap_start:
- Set by a CTRL write with b0=1.
- Cleared on an ap_ready pulse unless auto_restart=1; with auto_restart=1 it stays set.
- A CTRL write with b0=0 does not clear it.

ap_done latch:
- Set by the ap_done pulse; cleared by the AR handshake of a CTRL read.
- If set and clear happen in the same cycle, set wins.
- The read returns the pre-clear value.

ISR:
- b0 is set by ap_done when IER.b0=1; b1 is set by ap_ready when IER.b1=1.
- On a same-cycle W1C and set, set wins.

Simultaneous reads and writes to the same register are independent. A read returns the value from before the write's update cycle.

Reset mid-transaction aborts the transaction with no response; the master is reset alongside.

Decomposition:
- Package srai_accel_ctrl_pkg holds:
  - address constants CTRL_OFS, GIE_OFS, IER_OFS, ISR_OFS, ARG_BASE;
  - CTRL bit-index localparams;
  - typedef enum wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - resp constant RESP_OKAY.
- One sub-module, srai_accel_ctrl_regs: a byte-masked register bank with write port and combinational read mux. The parent keeps the AXI FSMs and ap_ctrl logic.

Test Plan:
- Reset, then read 0x00 with ap_idle=1 -> rdata=0x4, rresp=0, rvalid one cycle after AR handshake.
- Write ARG[2]=0xDEADBEEF with wstrb=0x3, prior value 0x11223344; W sent 3 cycles before AW -> single bvalid; readback 0x1122BEEF; args[95:64] match.
- Write CTRL=0x1, then pulse ap_ready -> ap_start=1 until the cycle after the ap_ready pulse, then 0. Repeat with CTRL=0x81 -> ap_start stays 1.
- GIE=1, IER=1, pulse ap_done:
  - -> interrupt=1; CTRL read returns b1=1 and the next CTRL read returns b1=0;
  - ISR write 0x1 -> interrupt=0;
  - with ap_done pulsing in the same cycle as the W1C -> ISR.b0 stays 1.
- Hold bready=0 for 5 cycles after a write and rready=0 for 5 cycles after a read -> bvalid, rvalid and rdata stable; awready, wready and arready stay 0 throughout.
- Read 0x7F0 (unmapped) -> rdata=0, rresp=0. Assert ap_rst_n=0 while rvalid=1 -> rvalid=0 immediately; all registers read back 0 after reset.

Source files
------------

// File: rtl/srai_accel_ctrl_pkg.sv
// Shared constants and types for the accelerator AXI-Lite control/status slave.
package srai_accel_ctrl_pkg;

    localparam logic [11:0] CTRL_OFS = 12'h000;
    localparam logic [11:0] GIE_OFS  = 12'h004;
    localparam logic [11:0] IER_OFS  = 12'h008;
    localparam logic [11:0] ISR_OFS  = 12'h00C;
    localparam logic [11:0] ARG_BASE = 12'h010;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;
    localparam int CTRL_READY_BIT = 3;
    localparam int CTRL_AUTO_BIT  = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/srai_accel_axi_lite_intfc.sv
// AXI-Lite bundle shared by the host interconnect and the control slave.
interface srai_accel_AXI_LITE_intfc #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/srai_accel_ctrl_regs.sv
// Byte-masked bank of kernel scalar argument registers with a combinational read port.
module srai_accel_ctrl_regs
    import srai_accel_ctrl_pkg::*;
#(
    parameter int NUM_ARGS = 8,
    parameter int AIW      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AIW-1:0]         wr_idx,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_strb,
    input  logic [AIW-1:0]         rd_idx,
    output logic [31:0]            rd_data,
    output logic [NUM_ARGS*32-1:0] args
);

    logic [31:0] bank [NUM_ARGS];
    logic [31:0] mask;

    assign mask = strb_mask(wr_strb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                if (wr_en && wr_idx == AIW'(i)) begin
                    bank[i] <= (bank[i] & ~mask) | (wr_data & mask);
                end
            end
        end
    end

    // Loop-compare rather than direct indexing keeps non-power-of-two banks in range.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (rd_idx == AIW'(i)) begin
                rd_data = bank[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
        assign args[32*g +: 32] = bank[g];
    end

endmodule

// File: rtl/srai_accel_ctrl_slave.sv
// AXI-Lite control/status slave bridging a host master to an ap_ctrl_hs kernel.
//   state  | meaning
//   W_IDLE | collecting AW and W (either order); update + bvalid once both are held
//   W_RESP | bvalid high, waiting for bready
//   R_IDLE | arready high, waiting for an address
//   R_DATA | rvalid/rdata held until rready
module srai_accel_ctrl_slave
    import srai_accel_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int NUM_ARGS = 8
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    srai_accel_AXI_LITE_intfc.slave s_axi,
    output logic                    ap_start,
    input  logic                    ap_done,
    input  logic                    ap_idle,
    input  logic                    ap_ready,
    output logic [NUM_ARGS*32-1:0]  args,
    output logic                    interrupt
);

    localparam int AIW = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
    localparam int WW  = ADDR_W - 2;

    localparam logic [WW-1:0] CTRL_WORD = WW'(CTRL_OFS >> 2);
    localparam logic [WW-1:0] GIE_WORD  = WW'(GIE_OFS >> 2);
    localparam logic [WW-1:0] IER_WORD  = WW'(IER_OFS >> 2);
    localparam logic [WW-1:0] ISR_WORD  = WW'(ISR_OFS >> 2);
    localparam logic [WW-1:0] ARG_LO    = WW'(ARG_BASE >> 2);
    localparam logic [WW-1:0] ARG_HI    = WW'((ARG_BASE >> 2) + NUM_ARGS);

    wr_state_t           wr_state;
    rd_state_t           rd_state;
    logic                aw_held;
    logic                w_held;
    logic [WW-1:0]       aw_word;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                wr_en;
    logic [WW-1:0]       ar_word;
    logic                ar_hs;
    logic                gie;
    logic                auto_restart;
    logic                done_latch;
    logic [1:0]          ier;
    logic [1:0]          isr;
    logic                aw_arg_hit;
    logic                ar_arg_hit;
    logic [AIW-1:0]      aw_idx;
    logic [AIW-1:0]      ar_idx;
    logic [31:0]         arg_rd_data;
    logic [DATA_W-1:0]   rd_word;
    logic                ctrl_wr;
    logic                gie_wr;
    logic                ier_wr;
    logic                isr_wr;
    logic                ctrl_rd_hs;
    logic                unused_bits;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign wr_en      = (wr_state == W_IDLE) && aw_held && w_held;
    assign ar_word    = s_axi.araddr[ADDR_W-1:2];
    assign ar_hs      = s_axi.arvalid && s_axi.arready;
    assign aw_arg_hit = (aw_word >= ARG_LO) && (aw_word < ARG_HI);
    assign ar_arg_hit = (ar_word >= ARG_LO) && (ar_word < ARG_HI);
    assign aw_idx     = AIW'(aw_word - ARG_LO);
    assign ar_idx     = AIW'(ar_word - ARG_LO);

    // Control fields all live in byte 0, so only wstrb[0] gates them.
    assign ctrl_wr    = wr_en && wstrb_q[0] && (aw_word == CTRL_WORD);
    assign gie_wr     = wr_en && wstrb_q[0] && (aw_word == GIE_WORD);
    assign ier_wr     = wr_en && wstrb_q[0] && (aw_word == IER_WORD);
    assign isr_wr     = wr_en && wstrb_q[0] && (aw_word == ISR_WORD);
    assign ctrl_rd_hs = ar_hs && (ar_word == CTRL_WORD);

    assign interrupt  = gie & |(isr & ier);

    srai_accel_ctrl_regs #(
        .NUM_ARGS (NUM_ARGS),
        .AIW      (AIW)
    ) u_regs (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (wr_en && aw_arg_hit),
        .wr_idx  (aw_idx),
        .wr_data (wdata_q),
        .wr_strb (wstrb_q),
        .rd_idx  (ar_idx),
        .rd_data (arg_rd_data),
        .args    (args)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_state      <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_word       <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (s_axi.awvalid && s_axi.awready) begin
                        aw_held       <= 1'b1;
                        aw_word       <= s_axi.awaddr[ADDR_W-1:2];
                        s_axi.awready <= 1'b0;
                    end else if (!aw_held) begin
                        s_axi.awready <= 1'b1;
                    end
                    if (s_axi.wvalid && s_axi.wready) begin
                        w_held       <= 1'b1;
                        wdata_q      <= s_axi.wdata;
                        wstrb_q      <= s_axi.wstrb;
                        s_axi.wready <= 1'b0;
                    end else if (!w_held) begin
                        s_axi.wready <= 1'b1;
                    end
                    if (aw_held && w_held) begin
                        wr_state     <= W_RESP;
                        s_axi.bvalid <= 1'b1;
                        s_axi.bresp  <= RESP_OKAY;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        wr_state      <= W_IDLE;
                        s_axi.bvalid  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        if (ar_word == CTRL_WORD) begin
            rd_word[CTRL_START_BIT] = ap_start;
            rd_word[CTRL_DONE_BIT]  = done_latch;
            rd_word[CTRL_IDLE_BIT]  = ap_idle;
            rd_word[CTRL_READY_BIT] = ap_ready;
            rd_word[CTRL_AUTO_BIT]  = auto_restart;
        end else if (ar_word == GIE_WORD) begin
            rd_word[0] = gie;
        end else if (ar_word == IER_WORD) begin
            rd_word[1:0] = ier;
        end else if (ar_word == ISR_WORD) begin
            rd_word[1:0] = isr;
        end else if (ar_arg_hit) begin
            rd_word = arg_rd_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_state      <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state      <= R_DATA;
                        s_axi.arready <= 1'b0;
                        s_axi.rvalid  <= 1'b1;
                        s_axi.rdata   <= rd_word;
                        s_axi.rresp   <= RESP_OKAY;
                    end else begin
                        s_axi.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rd_state      <= R_IDLE;
                        s_axi.rvalid  <= 1'b0;
                        s_axi.arready <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            done_latch   <= 1'b0;
            gie          <= 1'b0;
            ier          <= 2'b00;
            isr          <= 2'b00;
        end else begin
            if (ctrl_wr) begin
                auto_restart <= wdata_q[CTRL_AUTO_BIT];
            end
            if (ctrl_wr && wdata_q[CTRL_START_BIT]) begin
                ap_start <= 1'b1;
            end else if (ap_ready && !auto_restart) begin
                ap_start <= 1'b0;
            end
            if (ap_done) begin
                done_latch <= 1'b1;
            end else if (ctrl_rd_hs) begin
                done_latch <= 1'b0;
            end
            if (gie_wr) begin
                gie <= wdata_q[0];
            end
            if (ier_wr) begin
                ier <= wdata_q[1:0];
            end
            // New events outrank a simultaneous write-1-to-clear.
            isr <= (isr & ~(isr_wr ? wdata_q[1:0] : 2'b00))
                 | {ap_ready & ier[1], ap_done & ier[0]};
        end
    end

endmodule

// File: tb/tb_srai_accel_ctrl_slave.sv
// Directed test of the accelerator AXI-Lite control slave against hand-computed values.
module tb_srai_accel_ctrl_slave;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n;
    logic         ap_start;
    logic         ap_done;
    logic         ap_idle;
    logic         ap_ready;
    logic [255:0] args;
    logic         interrupt;
    int           total = 0;
    int           bad = 0;
    logic [31:0]  rd;
    logic [1:0]   rr;

    srai_accel_AXI_LITE_intfc #(.ADDR_W(12), .DATA_W(32)) axi ();

    srai_accel_ctrl_slave #(.ADDR_W(12), .DATA_W(32), .NUM_ARGS(8)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .s_axi     (axi),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .args      (args),
        .interrupt (interrupt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay,
                             input int b_stall, input bit done_at_update);
        bit aw_done = 0;
        bit w_done = 0;
        bit hs_aw;
        bit hs_w;
        bit early = 0;
        @(negedge ap_clk);
        axi.awaddr = addr;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            if (cyc == aw_delay) axi.awvalid = 1'b1;
            if (axi.bvalid) early = 1;
            hs_aw = axi.awvalid && axi.awready;
            hs_w  = axi.wvalid && axi.wready;
            @(negedge ap_clk);
            if (hs_aw) begin axi.awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin axi.wvalid  = 1'b0; w_done  = 1; end
        end
        chk("w_handshakes", 32'({aw_done, w_done}), 32'h3);
        chk("b_early", 32'(early), 32'h0);
        ap_done = done_at_update;
        for (int cyc = 0; cyc < 20 && !axi.bvalid; cyc++) @(negedge ap_clk);
        ap_done = 1'b0;
        chk("bvalid", 32'(axi.bvalid), 32'h1);
        chk("bresp", 32'(axi.bresp), 32'h0);
        for (int i = 0; i < b_stall; i++) begin
            @(negedge ap_clk);
            chk("b_hold", 32'(axi.bvalid), 32'h1);
            chk("b_awready_low", 32'({axi.awready, axi.wready}), 32'h0);
        end
        axi.bready = 1'b1;
        @(negedge ap_clk);
        axi.bready = 1'b0;
        chk("b_done", 32'(axi.bvalid), 32'h0);
        chk("aw_w_ready_back", 32'({axi.awready, axi.wready}), 32'h3);
    endtask

    task automatic axi_read(input logic [11:0] addr, input int r_stall,
                            output logic [31:0] data, output logic [1:0] resp);
        @(negedge ap_clk);
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        for (int cyc = 0; cyc < 20 && !axi.arready; cyc++) @(negedge ap_clk);
        @(negedge ap_clk);
        axi.arvalid = 1'b0;
        chk("rd_lat", 32'(axi.rvalid), 32'h1);
        data = axi.rdata;
        resp = axi.rresp;
        for (int i = 0; i < r_stall; i++) begin
            @(negedge ap_clk);
            chk("r_hold_valid", 32'(axi.rvalid), 32'h1);
            chk("r_hold_data", axi.rdata, data);
            chk("r_arready_low", 32'(axi.arready), 32'h0);
        end
        axi.rready = 1'b1;
        @(negedge ap_clk);
        axi.rready = 1'b0;
        chk("r_done", 32'(axi.rvalid), 32'h0);
        chk("arready_back", 32'(axi.arready), 32'h1);
    endtask

    task automatic pulse_ready();
        @(negedge ap_clk);
        ap_ready = 1'b1;
        @(negedge ap_clk);
        ap_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b1;
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);

        chk("rst_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'h0);
        chk("rst_valid", 32'({axi.bvalid, axi.rvalid}), 32'h0);
        chk("rst_rdata", axi.rdata, 32'h0);
        chk("rst_outs", 32'({ap_start, interrupt, |args}), 32'h0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("ready_after_rst", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);

        axi_read(12'h000, 0, rd, rr);
        chk("ctrl_idle", rd, 32'h4);
        chk("ctrl_rresp", 32'(rr), 32'h0);

        axi_write(12'h018, 32'h11223344, 4'hF, 0, 0, 1'b0);
        axi_write(12'h018, 32'hDEADBEEF, 4'h3, 3, 0, 1'b0);
        axi_read(12'h018, 0, rd, rr);
        chk("arg2_strb", rd, 32'h1122BEEF);
        chk("arg2_port", args[95:64], 32'h1122BEEF);

        axi_write(12'h000, 32'h1, 4'hF, 0, 0, 1'b0);
        chk("start_set", 32'(ap_start), 32'h1);
        @(negedge ap_clk);
        ap_ready = 1'b1;
        chk("start_during_ready", 32'(ap_start), 32'h1);
        @(negedge ap_clk);
        ap_ready = 1'b0;
        chk("start_cleared", 32'(ap_start), 32'h0);

        axi_write(12'h000, 32'h81, 4'hF, 0, 0, 1'b0);
        axi_read(12'h000, 0, rd, rr);
        chk("ctrl_auto", rd, 32'h85);
        pulse_ready();
        chk("start_auto_kept", 32'(ap_start), 32'h1);
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, 1'b0);
        chk("start_w0_kept", 32'(ap_start), 32'h1);
        pulse_ready();
        chk("start_cleared2", 32'(ap_start), 32'h0);

        ap_idle = 1'b0;
        axi_write(12'h004, 32'h1, 4'hF, 0, 0, 1'b0);
        axi_write(12'h008, 32'h1, 4'hF, 0, 0, 1'b0);
        chk("irq_none", 32'(interrupt), 32'h0);
        @(negedge ap_clk);
        ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        chk("irq_done", 32'(interrupt), 32'h1);
        axi_read(12'h000, 0, rd, rr);
        chk("ctrl_done_set", rd, 32'h2);
        axi_read(12'h000, 0, rd, rr);
        chk("ctrl_done_cor", rd, 32'h0);
        axi_write(12'h00C, 32'h1, 4'hF, 0, 0, 1'b0);
        chk("irq_w1c", 32'(interrupt), 32'h0);
        axi_write(12'h00C, 32'h1, 4'hF, 0, 0, 1'b1);
        axi_read(12'h00C, 0, rd, rr);
        chk("isr_set_wins", rd, 32'h1);
        chk("irq_set_wins", 32'(interrupt), 32'h1);

        axi_write(12'h008, 32'h3, 4'hF, 0, 0, 1'b0);
        axi_write(12'h00C, 32'h1, 4'hF, 0, 0, 1'b0);
        chk("irq_cleared", 32'(interrupt), 32'h0);
        pulse_ready();
        axi_read(12'h00C, 0, rd, rr);
        chk("isr_ready", rd, 32'h2);
        chk("irq_ready", 32'(interrupt), 32'h1);

        axi_write(12'h010, 32'hA5A55A5A, 4'hF, 0, 5, 1'b0);
        axi_read(12'h010, 5, rd, rr);
        chk("arg0_stall", rd, 32'hA5A55A5A);

        axi_read(12'h7F0, 0, rd, rr);
        chk("unmapped_data", rd, 32'h0);
        chk("unmapped_resp", 32'(rr), 32'h0);

        @(negedge ap_clk);
        axi.araddr  = 12'h018;
        axi.arvalid = 1'b1;
        for (int cyc = 0; cyc < 20 && !axi.arready; cyc++) @(negedge ap_clk);
        @(negedge ap_clk);
        axi.arvalid = 1'b0;
        chk("pre_rst_rvalid", 32'(axi.rvalid), 32'h1);
        ap_rst_n = 1'b0;
        #1;
        chk("rst_rvalid", 32'(axi.rvalid), 32'h0);
        chk("rst_arready", 32'(axi.arready), 32'h0);
        chk("rst_irq", 32'(interrupt), 32'h0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        axi_read(12'h000, 0, rd, rr);
        chk("post_rst_ctrl", rd, 32'h0);
        axi_read(12'h004, 0, rd, rr);
        chk("post_rst_gie", rd, 32'h0);
        axi_read(12'h008, 0, rd, rr);
        chk("post_rst_ier", rd, 32'h0);
        axi_read(12'h00C, 0, rd, rr);
        chk("post_rst_isr", rd, 32'h0);
        axi_read(12'h018, 0, rd, rr);
        chk("post_rst_arg2", rd, 32'h0);
        chk("post_rst_args", 32'(|args), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
